// File: rtl/commit_chk_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : commit_chk_pkg
//  Brief    : Shared error-flag positions, checker state and commit record.
//  Revision : 1.0
// ============================================================================
package commit_chk_pkg;

    localparam int c_err_kind_w  = 3;
    localparam int c_err_pc_bit  = 2;
    localparam int c_err_rd_bit  = 1;
    localparam int c_err_dat_bit = 0;

    localparam int c_rec_xlen    = 32;
    localparam int c_rec_raddr_w = 5;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } chk_state_t;

    // Default-width view of one retired instruction as seen by the checker.
    typedef struct packed {
        logic [c_rec_xlen-1:0]    pc;
        logic [c_rec_raddr_w-1:0] rd;
        logic [c_rec_xlen-1:0]    data;
    } commit_rec_t;

endpackage
`default_nettype wire

// File: rtl/commit_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : commit_fifo
//  Brief    : Synchronous FIFO, power-of-two depth, wrap-bit full/empty.
//  Revision : 1.0
// ============================================================================
module commit_fifo #(
    parameter int WIDTH = 69,
    parameter int DEPTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full
);
    localparam int c_aw = $clog2(DEPTH);

    logic [c_aw:0]      r_wptr;
    logic [c_aw:0]      r_rptr;
    logic [WIDTH-1:0]   r_mem [DEPTH];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (i_clear) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + 1'b1;
            if (i_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push && !i_clear) r_mem[r_wptr[c_aw-1:0]] <= i_data;
    end

    assign o_data  = r_mem[r_rptr[c_aw-1:0]];
    assign o_empty = (r_wptr == r_rptr);
    // Same slot but different lap means the writer is a full turn ahead.
    assign o_full  = (r_wptr[c_aw] != r_rptr[c_aw]) &&
                     (r_wptr[c_aw-1:0] == r_rptr[c_aw-1:0]);

endmodule
`default_nettype wire

// File: rtl/commit_checker.sv
`default_nettype none
// ============================================================================
//  Module   : commit_checker
//  Brief    : Lock-step compare of expected vs actual commit streams.
//  Revision : 1.0
// ============================================================================
module commit_checker
    import commit_chk_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int RADDR_W     = 5,
    parameter int DEPTH       = 8,
    parameter int STOP_ON_ERR = 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_exp_valid,
    output logic               o_exp_ready,
    input  logic [XLEN-1:0]    i_exp_pc,
    input  logic [RADDR_W-1:0] i_exp_rd,
    input  logic [XLEN-1:0]    i_exp_data,
    input  logic               i_act_valid,
    output logic               o_act_ready,
    input  logic [XLEN-1:0]    i_act_pc,
    input  logic [RADDR_W-1:0] i_act_rd,
    input  logic [XLEN-1:0]    i_act_data,
    input  logic               i_clear,
    output logic               o_mismatch,
    output logic [2:0]         o_err_kind,
    output logic [XLEN-1:0]    o_err_pc,
    output logic [31:0]        o_match_cnt,
    output logic [31:0]        o_mismatch_cnt,
    output logic               o_halted,
    output logic               o_overflow
);
    localparam int c_rec_w = 2 * XLEN + RADDR_W;

    chk_state_t           r_state;
    chk_state_t           w_state_nxt;

    logic [c_rec_w-1:0]   w_exp_head;
    logic [c_rec_w-1:0]   w_act_head;
    logic                 w_exp_empty;
    logic                 w_exp_full;
    logic                 w_act_empty;
    logic                 w_act_full;
    logic                 w_exp_push;
    logic                 w_act_push;
    logic                 w_cmp;
    logic                 w_bad;
    logic                 w_ovf_evt;
    logic [c_err_kind_w-1:0] w_kind;

    logic [XLEN-1:0]      w_exp_pc;
    logic [XLEN-1:0]      w_act_pc;
    logic [XLEN-1:0]      w_exp_data;
    logic [XLEN-1:0]      w_act_data;
    logic [RADDR_W-1:0]   w_exp_rd;
    logic [RADDR_W-1:0]   w_act_rd;

    logic                 r_mismatch;
    logic [2:0]           r_err_kind;
    logic [XLEN-1:0]      r_err_pc;
    logic [31:0]          r_match_cnt;
    logic [31:0]          r_mismatch_cnt;
    logic                 r_overflow;

    assign o_exp_ready = !w_exp_full && (r_state == ST_RUN);
    assign o_act_ready = !w_act_full && (r_state == ST_RUN);
    assign w_exp_push  = i_exp_valid && o_exp_ready;
    assign w_act_push  = i_act_valid && o_act_ready;
    assign w_ovf_evt   = (i_exp_valid && !o_exp_ready) || (i_act_valid && !o_act_ready);
    assign w_cmp       = !w_exp_empty && !w_act_empty && (r_state == ST_RUN) && !i_clear;

    commit_fifo #(
        .WIDTH (c_rec_w),
        .DEPTH (DEPTH)
    ) u_exp_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (i_clear),
        .i_push  (w_exp_push),
        .i_data  ({i_exp_pc, i_exp_rd, i_exp_data}),
        .i_pop   (w_cmp),
        .o_data  (w_exp_head),
        .o_empty (w_exp_empty),
        .o_full  (w_exp_full)
    );

    commit_fifo #(
        .WIDTH (c_rec_w),
        .DEPTH (DEPTH)
    ) u_act_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (i_clear),
        .i_push  (w_act_push),
        .i_data  ({i_act_pc, i_act_rd, i_act_data}),
        .i_pop   (w_cmp),
        .o_data  (w_act_head),
        .o_empty (w_act_empty),
        .o_full  (w_act_full)
    );

    assign {w_exp_pc, w_exp_rd, w_exp_data} = w_exp_head;
    assign {w_act_pc, w_act_rd, w_act_data} = w_act_head;

    // Writes to x0 are architecturally discarded, so their data is not compared.
    always_comb begin
        w_kind                = '0;
        w_kind[c_err_pc_bit]  = (w_exp_pc != w_act_pc);
        w_kind[c_err_rd_bit]  = (w_exp_rd != w_act_rd);
        w_kind[c_err_dat_bit] = (w_exp_data != w_act_data) && (w_exp_rd != '0);
        w_bad                 = (w_kind != '0);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= ST_RUN;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (i_clear)
            w_state_nxt = ST_RUN;
        else if ((r_state == ST_RUN) && w_cmp && w_bad && (STOP_ON_ERR != 0))
            w_state_nxt = ST_HALT;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mismatch     <= 1'b0;
            r_err_kind     <= '0;
            r_err_pc       <= '0;
            r_match_cnt    <= '0;
            r_mismatch_cnt <= '0;
            r_overflow     <= 1'b0;
        end else if (i_clear) begin
            r_mismatch     <= 1'b0;
            r_err_kind     <= '0;
            r_err_pc       <= '0;
            r_match_cnt    <= '0;
            r_mismatch_cnt <= '0;
            r_overflow     <= 1'b0;
        end else begin
            r_mismatch <= w_cmp && w_bad;
            if (w_ovf_evt) r_overflow <= 1'b1;
            if (w_cmp && w_bad) begin
                if (r_mismatch_cnt != 32'hFFFF_FFFF) r_mismatch_cnt <= r_mismatch_cnt + 32'd1;
                if (r_err_kind == '0) begin
                    r_err_kind <= w_kind;
                    r_err_pc   <= w_exp_pc;
                end
            end else if (w_cmp) begin
                if (r_match_cnt != 32'hFFFF_FFFF) r_match_cnt <= r_match_cnt + 32'd1;
            end
        end
    end

    assign o_mismatch     = r_mismatch;
    assign o_err_kind     = r_err_kind;
    assign o_err_pc       = r_err_pc;
    assign o_match_cnt    = r_match_cnt;
    assign o_mismatch_cnt = r_mismatch_cnt;
    assign o_halted       = (r_state == ST_HALT);
    assign o_overflow     = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_commit_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_commit_checker
//  Brief    : Directed bench; instance 0 halts on error, instance 1 counts on.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_commit_checker;
    import commit_chk_pkg::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        ev  = 1'b0;
    logic        av  = 1'b0;
    commit_rec_t erec = '0;
    commit_rec_t arec = '0;

    logic [1:0]  exp_rdy, act_rdy, mism, halted, ovf;
    logic [2:0]  ekind [2];
    logic [31:0] epc [2];
    logic [31:0] mc  [2];
    logic [31:0] mmc [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    commit_checker #(.XLEN(32), .RADDR_W(5), .DEPTH(DEPTH), .STOP_ON_ERR(1)) u_dut (
        .i_clk(clk), .i_rst(rst),
        .i_exp_valid(ev), .o_exp_ready(exp_rdy[0]),
        .i_exp_pc(erec.pc), .i_exp_rd(erec.rd), .i_exp_data(erec.data),
        .i_act_valid(av), .o_act_ready(act_rdy[0]),
        .i_act_pc(arec.pc), .i_act_rd(arec.rd), .i_act_data(arec.data),
        .i_clear(clr), .o_mismatch(mism[0]), .o_err_kind(ekind[0]), .o_err_pc(epc[0]),
        .o_match_cnt(mc[0]), .o_mismatch_cnt(mmc[0]), .o_halted(halted[0]), .o_overflow(ovf[0])
    );

    commit_checker #(.XLEN(32), .RADDR_W(5), .DEPTH(DEPTH), .STOP_ON_ERR(0)) u_dut_nh (
        .i_clk(clk), .i_rst(rst),
        .i_exp_valid(ev), .o_exp_ready(exp_rdy[1]),
        .i_exp_pc(erec.pc), .i_exp_rd(erec.rd), .i_exp_data(erec.data),
        .i_act_valid(av), .o_act_ready(act_rdy[1]),
        .i_act_pc(arec.pc), .i_act_rd(arec.rd), .i_act_data(arec.data),
        .i_clear(clr), .o_mismatch(mism[1]), .o_err_kind(ekind[1]), .o_err_pc(epc[1]),
        .o_match_cnt(mc[1]), .o_mismatch_cnt(mmc[1]), .o_halted(halted[1]), .o_overflow(ovf[1])
    );

    // Reference model: per-instance queues as shift arrays plus scalar status.
    commit_rec_t m_exp [2][DEPTH];
    commit_rec_t m_act [2][DEPTH];
    int          m_en  [2];
    int          m_an  [2];
    bit          m_halt[2];
    bit          m_mism[2];
    bit          m_ovf [2];
    logic [2:0]  m_kind[2];
    logic [31:0] m_epc [2];
    logic [31:0] m_mc  [2];
    logic [31:0] m_mmc [2];

    task automatic m_reset(input int k);
        m_en[k] = 0; m_an[k] = 0; m_halt[k] = 0; m_mism[k] = 0; m_ovf[k] = 0;
        m_kind[k] = '0; m_epc[k] = '0; m_mc[k] = '0; m_mmc[k] = '0;
    endtask

    task automatic m_step(input int k, input bit stop);
        bit er, ar, cmp;
        logic [2:0] kd;
        commit_rec_t e, a;
        er = !m_halt[k] && (m_en[k] < DEPTH);
        ar = !m_halt[k] && (m_an[k] < DEPTH);
        if (clr) begin
            m_reset(k);
        end else begin
            if ((ev && !er) || (av && !ar)) m_ovf[k] = 1'b1;
            cmp = !m_halt[k] && (m_en[k] > 0) && (m_an[k] > 0);
            m_mism[k] = 1'b0;
            if (cmp) begin
                e = m_exp[k][0];
                a = m_act[k][0];
                for (int i = 0; i < DEPTH - 1; i++) begin
                    m_exp[k][i] = m_exp[k][i+1];
                    m_act[k][i] = m_act[k][i+1];
                end
                m_en[k]--; m_an[k]--;
                kd = {e.pc != a.pc, e.rd != a.rd, (e.data != a.data) && (e.rd != 5'd0)};
                if (kd != 3'b000) begin
                    m_mism[k] = 1'b1;
                    if (m_mmc[k] != 32'hFFFF_FFFF) m_mmc[k]++;
                    if (m_kind[k] == 3'b000) begin m_kind[k] = kd; m_epc[k] = e.pc; end
                    if (stop) m_halt[k] = 1'b1;
                end else if (m_mc[k] != 32'hFFFF_FFFF) begin
                    m_mc[k]++;
                end
            end
            if (ev && er) begin m_exp[k][m_en[k]] = erec; m_en[k]++; end
            if (av && ar) begin m_act[k][m_an[k]] = arec; m_an[k]++; end
        end
    endtask

    initial begin
        m_reset(0); m_reset(1);
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin m_reset(0); m_reset(1); end
            else begin m_step(0, 1'b1); m_step(1, 1'b0); end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("u%0d_exp_ready", k), 32'(exp_rdy[k]), 32'(!m_halt[k] && (m_en[k] < DEPTH)));
                chk($sformatf("u%0d_act_ready", k), 32'(act_rdy[k]), 32'(!m_halt[k] && (m_an[k] < DEPTH)));
                chk($sformatf("u%0d_mismatch", k), 32'(mism[k]), 32'(m_mism[k]));
                chk($sformatf("u%0d_err_kind", k), 32'(ekind[k]), 32'(m_kind[k]));
                chk($sformatf("u%0d_err_pc", k), epc[k], m_epc[k]);
                chk($sformatf("u%0d_match_cnt", k), mc[k], m_mc[k]);
                chk($sformatf("u%0d_mismatch_cnt", k), mmc[k], m_mmc[k]);
                chk($sformatf("u%0d_halted", k), 32'(halted[k]), 32'(m_halt[k]));
                chk($sformatf("u%0d_overflow", k), 32'(ovf[k]), 32'(m_ovf[k]));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    function automatic commit_rec_t rec(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] d);
        commit_rec_t r;
        r.pc = pc; r.rd = rd; r.data = d;
        return r;
    endfunction

    task automatic do_clear();
        clr = 1'b1; cyc(1); clr = 1'b0;
    endtask

    initial begin
        cyc(3);
        rst = 1'b0;
        chk("rst_match_cnt", mc[0], 32'd0);
        chk("rst_err_kind", 32'(ekind[0]), 32'd0);
        chk("rst_exp_ready", 32'(exp_rdy[0]), 32'd1);

        // Single matching record: compare one cycle after push, count one after that.
        erec = rec(32'h100, 5'd5, 32'd7); arec = erec; ev = 1; av = 1;
        cyc(1); ev = 0; av = 0;
        chk("t34_cnt_in_cmp_cycle", mc[0], 32'd0);
        cyc(1);
        chk("t34_match_cnt", mc[0], 32'd1);
        chk("t34_no_mismatch", 32'(mism[0]), 32'd0);

        // Data differs on x0: still a match.
        erec = rec(32'h108, 5'd0, 32'd1); arec = rec(32'h108, 5'd0, 32'd0); ev = 1; av = 1;
        cyc(1); ev = 0; av = 0;
        cyc(1);
        chk("t36_x0_match", mc[0], 32'd2);
        chk("t36_no_mm", mmc[0], 32'd0);

        // Fill the actual FIFO alone, overflow it, then drain with matching expecteds.
        for (int i = 0; i < DEPTH; i++) begin
            av = 1; arec = rec(32'h200 + 32'(4 * i), 5'(i + 1), 32'(i * 3)); cyc(1);
        end
        av = 0;
        chk("t37_act_full", 32'(act_rdy[0]), 32'd0);
        av = 1; arec = rec(32'h220, 5'd9, 32'd99); cyc(1); av = 0;
        chk("t37_overflow", 32'(ovf[0]), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            ev = 1; erec = rec(32'h200 + 32'(4 * i), 5'(i + 1), 32'(i * 3)); cyc(1);
        end
        ev = 0; cyc(2);
        chk("t37_match_cnt", mc[0], 32'd10);
        chk("t37_act_ready", 32'(act_rdy[0]), 32'd1);

        do_clear();
        chk("clr_overflow", 32'(ovf[0]), 32'd0);
        chk("clr_match_cnt", mc[1], 32'd0);

        // Ten records, PC corrupted on records 2, 5 and 8.
        for (int i = 0; i < 10; i++) begin
            ev = 1; av = 1;
            erec = rec(32'h400 + 32'(4 * i), 5'(1 + i % 7), 32'(i + 20));
            arec = erec;
            if (i == 2 || i == 5 || i == 8) arec.pc = erec.pc ^ 32'h40;
            cyc(1);
        end
        ev = 0; av = 0; cyc(3);
        chk("t38_nh_mm_cnt", mmc[1], 32'd3);
        chk("t38_nh_match_cnt", mc[1], 32'd7);
        chk("t38_nh_kind", 32'(ekind[1]), 32'b100);
        chk("t38_nh_halted", 32'(halted[1]), 32'd0);
        chk("t38_h_halted", 32'(halted[0]), 32'd1);
        chk("t38_h_err_pc", epc[0], 32'h408);
        chk("t38_h_match_cnt", mc[0], 32'd2);

        do_clear();
        erec = rec(32'h500, 5'd4, 32'd9); arec = rec(32'h500, 5'd6, 32'd10); ev = 1; av = 1;
        cyc(1); ev = 0; av = 0; cyc(1);
        chk("rd_data_kind", 32'(ekind[1]), 32'b011);

        do_clear();
        erec = rec(32'h104, 5'd3, 32'd7); arec = rec(32'h104, 5'd3, 32'd8); ev = 1; av = 1;
        cyc(1); ev = 0; av = 0; cyc(1);
        chk("t35_mismatch", 32'(mism[0]), 32'd1);
        chk("t35_kind", 32'(ekind[0]), 32'b001);
        chk("t35_err_pc", epc[0], 32'h104);
        chk("t35_halted", 32'(halted[0]), 32'd1);
        chk("t35_exp_ready", 32'(exp_rdy[0]), 32'd0);
        chk("t35_act_ready", 32'(act_rdy[0]), 32'd0);
        cyc(1);
        chk("t35_pulse_once", 32'(mism[0]), 32'd0);
        erec = rec(32'h110, 5'd1, 32'd1); arec = erec; ev = 1; av = 1;
        cyc(2); ev = 0; av = 0; cyc(1);
        chk("t35_frozen_cnt", mc[0], 32'd0);

        // Reset while expecteds are pending: they must be discarded.
        do_clear();
        for (int i = 0; i < 4; i++) begin
            ev = 1; erec = rec(32'h600 + 32'(4 * i), 5'd1, 32'(i)); cyc(1);
        end
        ev = 0;
        rst = 1'b1; cyc(2); rst = 1'b0;
        chk("t39_err_kind", 32'(ekind[1]), 32'd0);
        chk("t39_overflow", 32'(ovf[0]), 32'd0);
        for (int i = 0; i < 2; i++) begin
            av = 1; arec = rec(32'h600 + 32'(4 * i), 5'd1, 32'(i)); cyc(1);
        end
        av = 0; cyc(2);
        chk("t39_no_cmp", mc[0], 32'd0);
        chk("t39_no_mm", mmc[1], 32'd0);
        for (int i = 0; i < 2; i++) begin
            ev = 1; erec = rec(32'h600 + 32'(4 * i), 5'd1, 32'(i)); cyc(1);
        end
        ev = 0; cyc(2);
        chk("t39_after_new", mc[0], 32'd2);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/commit_checker.md
COMMIT_CHECKER -- requirements
Module: commit_checker

Interface
REQ-001 SHALL have parameter XLEN, default 32, data and PC width.
REQ-002 SHALL have parameter RADDR_W, default 5, register index width.
REQ-003 SHALL have parameter DEPTH, default 8, per-channel FIFO entries, power of two, at least 2.
REQ-004 SHALL have parameter STOP_ON_ERR, default 1, where 1 halts on the first mismatch and 0 counts and continues.
REQ-005 SHALL have port i_clk, input, 1 bit, the single clock.
REQ-006 SHALL have port i_rst, input, 1 bit, reset that is asynchronous and active-high.
REQ-007 SHALL have ports i_exp_valid/o_exp_ready, input/output, 1 bit each, the expected-commit handshake from the reference model.
REQ-008 SHALL have ports i_exp_pc/i_exp_rd/i_exp_data, input, XLEN/RADDR_W/XLEN bits, the expected commit record.
REQ-009 SHALL have ports i_act_valid/o_act_ready, input/output, 1 bit each, the actual-commit handshake from the DUT writeback.
REQ-010 SHALL have ports i_act_pc/i_act_rd/i_act_data, input, XLEN/RADDR_W/XLEN bits, the actual commit record.
REQ-011 SHALL have port i_clear, input, 1 bit, a synchronous restart of counters and state.
REQ-012 SHALL have port o_mismatch, output, 1 bit, a one-cycle pulse per failing compare.
REQ-013 SHALL have port o_err_kind, output, 3 bits, sticky flags for the first error: {pc, rd, data}.
REQ-014 SHALL have port o_err_pc, output, XLEN bits, the expected PC of the first error.
REQ-015 SHALL have ports o_match_cnt/o_mismatch_cnt, output, 32 bits each, saturating counters.
REQ-016 SHALL have port o_halted, output, 1 bit, high while in state HALT.
REQ-017 SHALL have port o_overflow, output, 1 bit, sticky; set when valid is asserted while ready is low on either channel.

Function
REQ-018 Each channel SHALL push into its own FIFO when valid&&ready; ready = !full && state==RUN.
REQ-019 A compare SHALL occur in any cycle where both FIFOs are non-empty and state==RUN; both heads pop in that same cycle.
REQ-020 A compare SHALL flag pc if the PCs differ, rd if the rd fields differ, and data if the data differs and exp_rd!=0; data for x0 is ignored.
REQ-021 o_mismatch and the counter updates SHALL be registered: they occur one cycle after the compare cycle.
REQ-022 o_err_kind and o_err_pc SHALL be captured only when o_err_kind==0, so they record the first error.
REQ-023 The FSM SHALL have states RUN and HALT; RUN moves to HALT on a mismatch when STOP_ON_ERR=1; HALT is exited only by i_clear or i_rst.
REQ-024 In HALT, both ready signals SHALL be 0, no pops occur, and the FIFO contents are frozen.
REQ-025 A simultaneous push and pop on a full FIFO SHALL not be permitted, because ready=0 when full; a simultaneous push and pop on a non-full FIFO SHALL keep the count unchanged.
REQ-026 FIFO pointers SHALL wrap modulo DEPTH, and an extra MSB SHALL distinguish full from empty.
REQ-027 The counters SHALL saturate at 32'hFFFF_FFFF.
REQ-028 i_clear SHALL empty both FIFOs, zero the counters, o_err_kind, o_err_pc and o_overflow, and enter RUN on the next edge; it takes priority over pushes and compares in that cycle.

Reset
REQ-029 i_rst SHALL asynchronously force: state RUN, FIFOs empty, o_mismatch=0, o_err_kind=0, o_err_pc=0, both counters 0, o_halted=0, o_overflow=0.
REQ-030 After i_rst is released, ready SHALL be 1 on the first clock edge.
REQ-031 If reset is asserted mid-operation, pending entries SHALL be discarded and no mismatch pulse is produced.

Structure
REQ-032 A shared package commit_chk_pkg SHALL hold the err_kind bit positions, the FSM state enum and the commit-record struct type.
REQ-033 There SHALL be one sub-module, commit_fifo, a parametrised synchronous FIFO with async active-high reset, instantiated twice.

Verification
REQ-034 Push exp and act records {pc=0x100, rd=5, data=7} in the same cycle -> the compare happens one cycle later and o_match_cnt=1 the cycle after that, with o_mismatch=0.
REQ-035 With STOP_ON_ERR=1, push exp data=7 and act data=8 at rd=3, pc=0x104 -> o_mismatch pulses once, o_err_kind=3'b001, o_err_pc=0x104, o_halted=1, and both ready signals are 0.
REQ-036 Push exp rd=0 data=1 and act rd=0 data=0 -> counted as a match.
REQ-037 Push 8 act records with no exp records (DEPTH=8) -> o_act_ready=0, and a 9th valid sets o_overflow; then push 8 matching exp records -> o_match_cnt=8 and both FIFOs are empty.
REQ-038 With STOP_ON_ERR=0, inject 3 PC mismatches among 10 records -> o_mismatch_cnt=3, o_match_cnt=7, o_err_kind=3'b100, o_halted=0.
REQ-039 Assert i_rst while 4 entries are pending, then release -> all outputs are 0 and no compare occurs until new pushes arrive on both channels.
